jogador_automatico: RTL and testbench

JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

---
 rtl/jogo_pkg.sv | 32 +++
 rtl/contador_m.sv | 24 ++
 rtl/jogador_automatico.sv | 172 +++++++++++++++++
 tb/tb_jogador_automatico.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the memory game: controller state codes, color constants
// and small color helpers used by the control unit and the automatic player.
package jogo_pkg;

    localparam int unsigned COR_W = 4;

    typedef enum logic [3:0] {
        OCIOSO        = 4'd0,
        GRAVA         = 4'd1,
        ESPERA        = 4'd2,
        PRESSIONA     = 4'd3,
        SOLTA         = 4'd4,
        COR_PRESSIONA = 4'd5,
        COR_SOLTA     = 4'd6,
        FIM           = 4'd7
    } estado_t;

    localparam logic [COR_W-1:0] APAGADO      = 4'b0000;
    localparam logic [COR_W-1:0] COR_VERMELHO = 4'b0001;
    localparam logic [COR_W-1:0] COR_VERDE    = 4'b0010;
    localparam logic [COR_W-1:0] COR_AZUL     = 4'b0100;
    localparam logic [COR_W-1:0] COR_AMARELO  = 4'b1000;

    function automatic logic [COR_W-1:0] gira_esq(input logic [COR_W-1:0] v);
        return {v[COR_W-2:0], v[COR_W-1]};
    endfunction

    function automatic logic eh_cor(input logic [COR_W-1:0] v);
        return $onehot(v);
    endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear and enable; fim_c flags the last count.
module contador_m #(
    parameter int unsigned M = 20,
    localparam int unsigned W = (M > 1) ? $clog2(M) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] q,
    output logic         fim_c
);

    assign fim_c = (q == W'(M - 1));

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            q <= '0;
        end else if (enable) begin
            q <= fim_c ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player: records the sequence shown on the game LEDs and replays it
// on the buttons, optionally corrupting the last entry or appending a new color.
module jogador_automatico
    import jogo_pkg::*;
#(
    parameter int unsigned T_PRESS = 10,
    parameter int unsigned T_GAP   = 10,
    parameter int unsigned PROF    = 16,
    localparam int unsigned AW = $clog2(PROF),
    localparam int unsigned CW = $clog2(PROF) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          habilita,
    input  logic [3:0]    leds,
    input  logic          exibindo,
    input  logic          aguardando_jogada,
    input  logic          aguardando_cor,
    input  logic          fim_jogo,
    input  logic          errar,
    output logic [3:0]    botoes,
    output logic          ocupado,
    output logic [CW-1:0] contagem,
    output logic          overflow,
    output logic [3:0]    db_estado
);

    localparam int unsigned TM = T_PRESS + T_GAP;
    localparam int unsigned TW = $clog2(TM);

    estado_t         state, next;
    logic [3:0]      mem [PROF];
    logic [3:0]      leds_ant;
    logic            exibindo_ant;
    logic [CW-1:0]   index;
    logic [CW-1:0]   idx_n;
    logic [3:0]      nova_cor;
    logic [3:0]      valor_press;
    logic [TW-1:0]   q;
    logic            fim_c;
    logic            timer_clr, timer_en;
    logic            captura, limpa, ini_rep, avanca, gira_cor;
    logic            leds_sobe;

    contador_m #(.M(TM)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clr),
        .enable (timer_en),
        .q      (q),
        .fim_c  (fim_c)
    );

    assign leds_sobe = (leds_ant == APAGADO) && eh_cor(leds);
    assign db_estado = state;

    // Value latched into botoes when a replay press starts (index seen after this edge)
    always_comb begin
        idx_n       = (state == SOLTA) ? index + CW'(1) : '0;
        valor_press = mem[idx_n[AW-1:0]];
        if (errar && (idx_n + CW'(1) == contagem)) begin
            valor_press = gira_esq(valor_press);
        end
    end

    always_comb begin
        next      = state;
        captura   = 1'b0;
        limpa     = 1'b0;
        ini_rep   = 1'b0;
        avanca    = 1'b0;
        gira_cor  = 1'b0;
        timer_clr = 1'b1;
        timer_en  = 1'b0;
        case (state)
            OCIOSO: begin
                if (habilita && exibindo) begin
                    next  = GRAVA;
                    limpa = 1'b1;
                end
            end
            GRAVA: begin
                captura = leds_sobe;
                if (!exibindo) next = ESPERA;
            end
            ESPERA: begin
                if (aguardando_jogada && (contagem != '0)) begin
                    next    = PRESSIONA;
                    ini_rep = 1'b1;
                end else if (aguardando_cor) begin
                    next = COR_PRESSIONA;
                end else if (exibindo && !exibindo_ant) begin
                    next  = GRAVA;
                    limpa = 1'b1;
                end
            end
            PRESSIONA, COR_PRESSIONA: begin
                timer_clr = 1'b0;
                timer_en  = 1'b1;
                if (q == TW'(T_PRESS - 1)) begin
                    next = (state == PRESSIONA) ? SOLTA : COR_SOLTA;
                end
            end
            SOLTA: begin
                timer_clr = 1'b0;
                timer_en  = 1'b1;
                if (fim_c) begin
                    avanca = 1'b1;
                    next   = (index + CW'(1) == contagem) ? ESPERA : PRESSIONA;
                end
            end
            COR_SOLTA: begin
                timer_clr = 1'b0;
                timer_en  = 1'b1;
                if (fim_c) begin
                    gira_cor = 1'b1;
                    next     = ESPERA;
                end
            end
            FIM: begin
                if (!fim_jogo) next = OCIOSO;
            end
            default: next = OCIOSO;
        endcase
        if (fim_jogo && (state != OCIOSO)) next = FIM;
        if (!habilita) next = OCIOSO;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= OCIOSO;
            botoes       <= APAGADO;
            ocupado      <= 1'b0;
            contagem     <= '0;
            overflow     <= 1'b0;
            index        <= '0;
            nova_cor     <= COR_VERDE;
            leds_ant     <= APAGADO;
            exibindo_ant <= 1'b0;
        end else begin
            state        <= next;
            ocupado      <= (next != OCIOSO) && (next != FIM);
            leds_ant     <= leds;
            exibindo_ant <= exibindo;
            // Press values are sampled once on entry and held for the whole press
            if (next == PRESSIONA) begin
                if (state != PRESSIONA) botoes <= valor_press;
            end else if (next == COR_PRESSIONA) begin
                if (state != COR_PRESSIONA) botoes <= nova_cor;
            end else begin
                botoes <= APAGADO;
            end
            if (limpa) begin
                contagem <= '0;
                overflow <= 1'b0;
            end else if (captura) begin
                if (contagem == CW'(PROF)) overflow <= 1'b1;
                else                       contagem <= contagem + CW'(1);
            end
            if (ini_rep)     index <= '0;
            else if (avanca) index <= index + CW'(1);
            if (gira_cor) nova_cor <= gira_esq(nova_cor);
        end
    end

    always_ff @(posedge clock) begin
        if (captura && (contagem != CW'(PROF))) begin
            mem[contagem[AW-1:0]] <= leds;
        end
    end

endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico: recording, replay timing, color append,
// deliberate error, overflow, game end, and abort by habilita/reset.
module tb_jogador_automatico;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita, exibindo, aguardando_jogada, aguardando_cor, fim_jogo, errar;
    logic [3:0] leds;
    logic [3:0] botoes;
    logic       ocupado;
    logic [4:0] contagem;
    logic       overflow;
    logic [3:0] db_estado;
    logic [3:0] esp;
    logic [3:0] cor;

    int n_vetores = 0;
    int n_erros   = 0;

    jogador_automatico #(.T_PRESS(10), .T_GAP(10), .PROF(16)) dut (
        .clock             (clock),
        .reset             (reset),
        .habilita          (habilita),
        .leds              (leds),
        .exibindo          (exibindo),
        .aguardando_jogada (aguardando_jogada),
        .aguardando_cor    (aguardando_cor),
        .fim_jogo          (fim_jogo),
        .errar             (errar),
        .botoes            (botoes),
        .ocupado           (ocupado),
        .contagem          (contagem),
        .overflow          (overflow),
        .db_estado         (db_estado)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esperado);
        n_vetores++;
        if (obs !== esperado) begin
            n_erros++;
            $display("FAIL %s: obtido %0h esperado %0h", tag, obs, esperado);
        end
    endtask

    initial begin
        reset = 1'b1; habilita = 1'b0; exibindo = 1'b0; aguardando_jogada = 1'b0;
        aguardando_cor = 1'b0; fim_jogo = 1'b0; errar = 1'b0; leds = 4'b0000;
        tick(2);
        reset = 1'b0;
        confere("rst_botoes", 32'(botoes), 32'h0);
        confere("rst_contagem", 32'(contagem), 32'h0);
        confere("rst_overflow", 32'(overflow), 32'h0);
        confere("rst_ocupado", 32'(ocupado), 32'h0);
        confere("rst_estado", 32'(db_estado), 32'h0);

        // nova_cor reset value through a color append
        habilita = 1'b1; exibindo = 1'b1; tick();
        confere("grava_estado", 32'(db_estado), 32'h1);
        confere("grava_ocupado", 32'(ocupado), 32'h1);
        exibindo = 1'b0; tick();
        confere("espera_estado", 32'(db_estado), 32'h2);
        aguardando_cor = 1'b1; tick(); aguardando_cor = 1'b0;
        for (int i = 0; i < 20; i++) begin
            esp = (i < 10) ? 4'b0010 : 4'b0000;
            confere($sformatf("cor1_%0d", i), 32'(botoes), 32'(esp));
            tick();
        end
        confere("cor1_espera", 32'(db_estado), 32'h2);
        aguardando_cor = 1'b1; tick(); aguardando_cor = 1'b0;
        confere("cor2_botoes", 32'(botoes), 32'h4);
        tick(20);
        confere("cor2_espera", 32'(db_estado), 32'h2);

        // record 0001, 0010 with noise, then replay
        exibindo = 1'b1; tick();
        confere("grava2_contagem", 32'(contagem), 32'h0);
        leds = 4'b0001; tick();
        confere("cap1", 32'(contagem), 32'h1);
        tick(3);
        confere("cap1_hold", 32'(contagem), 32'h1);
        leds = 4'b0000; tick(); leds = 4'b0011; tick();
        confere("nao_onehot", 32'(contagem), 32'h1);
        leds = 4'b0000; tick(); leds = 4'b0010; tick();
        confere("cap2", 32'(contagem), 32'h2);
        leds = 4'b0000; tick(); exibindo = 1'b0; tick();
        confere("rep_espera", 32'(db_estado), 32'h2);
        aguardando_jogada = 1'b1; tick(); aguardando_jogada = 1'b0;
        for (int i = 0; i < 40; i++) begin
            esp = (i < 10) ? 4'b0001 : (i < 20) ? 4'b0000 : (i < 30) ? 4'b0010 : 4'b0000;
            confere($sformatf("rep_%0d", i), 32'(botoes), 32'(esp));
            tick();
        end
        confere("rep_fim_estado", 32'(db_estado), 32'h2);
        confere("rep_fim_botoes", 32'(botoes), 32'h0);

        // deliberate error on last entry: 0001, 1000 -> second press 0001
        exibindo = 1'b1; tick();
        leds = 4'b0001; tick(); leds = 4'b0000; tick();
        leds = 4'b1000; tick(); leds = 4'b0000; tick();
        exibindo = 1'b0; tick();
        confere("err_contagem", 32'(contagem), 32'h2);
        errar = 1'b1; aguardando_jogada = 1'b1; tick(); aguardando_jogada = 1'b0;
        confere("err_press0", 32'(botoes), 32'h1);
        tick(20);
        confere("err_press1", 32'(botoes), 32'h1);
        confere("err_press1_est", 32'(db_estado), 32'h3);
        tick(20);
        errar = 1'b0;
        confere("err_espera", 32'(db_estado), 32'h2);

        // game end mid-press, then release
        aguardando_jogada = 1'b1; tick(); aguardando_jogada = 1'b0;
        tick(2);
        fim_jogo = 1'b1; tick();
        confere("fim_estado", 32'(db_estado), 32'h7);
        confere("fim_botoes", 32'(botoes), 32'h0);
        confere("fim_ocupado", 32'(ocupado), 32'h0);
        fim_jogo = 1'b0; tick();
        confere("fim_ocioso", 32'(db_estado), 32'h0);

        // 17 flashes into a 16-entry memory
        exibindo = 1'b1; tick();
        cor = 4'b0001;
        for (int i = 0; i < 17; i++) begin
            leds = cor; tick(); leds = 4'b0000; tick();
            cor = {cor[2:0], cor[3]};
        end
        confere("ovf_contagem", 32'(contagem), 32'h10);
        confere("ovf_flag", 32'(overflow), 32'h1);
        exibindo = 1'b0; tick(); exibindo = 1'b1; tick();
        confere("ovf_clr_cont", 32'(contagem), 32'h0);
        confere("ovf_clr_flag", 32'(overflow), 32'h0);

        // habilita dropped at cycle 5 of a press
        leds = 4'b0100; tick(); leds = 4'b0000; tick();
        exibindo = 1'b0; tick();
        aguardando_jogada = 1'b1; tick(); aguardando_jogada = 1'b0;
        confere("ab_press", 32'(botoes), 32'h4);
        tick(4);
        habilita = 1'b0; tick();
        confere("ab_botoes", 32'(botoes), 32'h0);
        confere("ab_estado", 32'(db_estado), 32'h0);
        confere("ab_ocupado", 32'(ocupado), 32'h0);

        // reset mid-replay
        habilita = 1'b1; exibindo = 1'b1; tick();
        leds = 4'b0001; tick(); leds = 4'b0000; tick();
        exibindo = 1'b0; tick();
        aguardando_jogada = 1'b1; tick(); aguardando_jogada = 1'b0;
        confere("rr_press", 32'(botoes), 32'h1);
        tick(3);
        reset = 1'b1; tick(); reset = 1'b0;
        confere("rr_botoes", 32'(botoes), 32'h0);
        confere("rr_estado", 32'(db_estado), 32'h0);
        confere("rr_contagem", 32'(contagem), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vetores, n_erros);
        $finish;
    end

endmodule
